// File: rtl/yolov3_tiny_seq.sv
// yolov3_tiny_seq: layer sequencer for the YOLOv3-tiny accelerator.
// Walks layers 1..NUM_LAYER and presents each layer's configuration to the
// single-layer compute engine. It issues one layer_start pulse per layer and
// waits for that layer's layer_done. After the last layer it raises done_CNN.
// The reset input rst_n is synchronous and active-high, despite its name.
//
// Optional feature macro: PERF_CNT_EN
//   Adds the 32-bit cycle_cnt output. The counter clears when a start is
//   accepted. It counts every cycle spent in LAUNCH or RUN and holds its
//   value in DONE.
//
// Handshake: layer_start is a registered one-cycle pulse. layer_done is
// accepted only in RUN, and only in a cycle where layer_start is low.
// start_CNN is accepted only in IDLE or DONE.
module yolov3_tiny_seq #(
    parameter int SYSTOLIC_SIZE     = 16,
    parameter int DATA_WIDTH        = 64,
    parameter int INOUT_WIDTH       = 1024,
    parameter int IFM_RAM_SIZE      = 524172,
    parameter int WGT_RAM_SIZE      = 8845488,
    parameter int OFM_RAM_SIZE      = 2378675,
    parameter int MAX_WGT_FIFO_SIZE = 4608,
    parameter int RELU_PARAM        = 0,
    parameter int NUM_LAYER         = 8,
    // ifm_base addresses either the IFM RAM or the OFM RAM, so it must be
    // wide enough for the larger of the two.
    localparam int IFM_AW = ($clog2(IFM_RAM_SIZE) > $clog2(OFM_RAM_SIZE)) ?
                            $clog2(IFM_RAM_SIZE) : $clog2(OFM_RAM_SIZE),
    localparam int WGT_AW = $clog2(WGT_RAM_SIZE),
    localparam int OFM_AW = $clog2(OFM_RAM_SIZE)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_CNN,
    output logic                  done_CNN,
    output logic                  layer_start,
    input  logic                  layer_done,
    output logic [3:0]            count_layer,
    output logic [8:0]            ifm_size,
    output logic [10:0]           ifm_ch,
    output logic [10:0]           num_filter,
    output logic [1:0]            kernel_size,
    output logic                  pool_en,
    output logic                  relu_en,
    output logic [DATA_WIDTH-1:0] act_param,
    output logic                  ifm_src,
    output logic [IFM_AW-1:0]     ifm_base,
    output logic [WGT_AW-1:0]     wgt_base,
    output logic [OFM_AW-1:0]     ofm_base
`ifdef PERF_CNT_EN
    ,
    output logic [31:0]           cycle_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        RUN    = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Odd layers write to the ping half of the OFM RAM and even layers write
    // to the pong half. Each layer after the first reads the previous layer's output.
    localparam logic [OFM_AW-1:0] OFM_PING  = '0;
    localparam logic [OFM_AW-1:0] OFM_PONG  = OFM_AW'(526912);
    localparam logic [IFM_AW-1:0] IFM_PING  = '0;
    localparam logic [IFM_AW-1:0] IFM_PONG  = IFM_AW'(526912);
    localparam logic [3:0]        LAST_LAYER = 4'(NUM_LAYER);

    state_t state;

    assign act_param = DATA_WIDTH'(RELU_PARAM);

    // Sequencer FSM: start handling, per-layer launch pulse, and completion flag.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state       <= IDLE;
            count_layer <= 4'd0;
            layer_start <= 1'b0;
            done_CNN    <= 1'b0;
        end else begin
            layer_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_CNN) begin
                        count_layer <= 4'd1;
                        state       <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    layer_start <= 1'b1;
                    state       <= RUN;
                end
                RUN: begin
                    // A done that overlaps our own start pulse cannot belong
                    // to this layer, so it is dropped.
                    if (layer_done && !layer_start) begin
                        if (count_layer == LAST_LAYER) begin
                            done_CNN <= 1'b1;
                            state    <= DONE;
                        end else begin
                            count_layer <= count_layer + 4'd1;
                            state       <= LAUNCH;
                        end
                    end
                end
                DONE: begin
                    if (start_CNN) begin
                        done_CNN    <= 1'b0;
                        count_layer <= 4'd1;
                        state       <= LAUNCH;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef PERF_CNT_EN
    // Cycle counter: cleared on an accepted start, counts while a network run is active.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            cycle_cnt <= 32'd0;
        end else if ((state == IDLE || state == DONE) && start_CNN) begin
            cycle_cnt <= 32'd0;
        end else if (state == LAUNCH || state == RUN) begin
            cycle_cnt <= cycle_cnt + 32'd1;
        end
    end
`endif

    // Layer configuration ROM indexed by count_layer. All fields are zero when idle.
    always_comb begin
        ifm_size    = 9'd0;
        ifm_ch      = 11'd0;
        num_filter  = 11'd0;
        kernel_size = 2'd0;
        pool_en     = 1'b0;
        relu_en     = 1'b0;
        ifm_src     = 1'b0;
        ifm_base    = '0;
        wgt_base    = '0;
        ofm_base    = '0;
        case (count_layer)
            4'd1: begin
                ifm_size = 9'd318; ifm_ch = 11'd3;    num_filter = 11'd16;
                kernel_size = 2'd3; pool_en = 1'b1; relu_en = 1'b1;
                ifm_src = 1'b0; ifm_base = IFM_PING;
                wgt_base = WGT_AW'(0);       ofm_base = OFM_PING;
            end
            4'd2: begin
                ifm_size = 9'd159; ifm_ch = 11'd16;   num_filter = 11'd32;
                kernel_size = 2'd3; pool_en = 1'b1; relu_en = 1'b1;
                ifm_src = 1'b1; ifm_base = IFM_PING;
                wgt_base = WGT_AW'(432);     ofm_base = OFM_PONG;
            end
            4'd3: begin
                ifm_size = 9'd79;  ifm_ch = 11'd32;   num_filter = 11'd64;
                kernel_size = 2'd3; pool_en = 1'b1; relu_en = 1'b1;
                ifm_src = 1'b1; ifm_base = IFM_PONG;
                wgt_base = WGT_AW'(5040);    ofm_base = OFM_PING;
            end
            4'd4: begin
                ifm_size = 9'd39;  ifm_ch = 11'd64;   num_filter = 11'd128;
                kernel_size = 2'd3; pool_en = 1'b1; relu_en = 1'b1;
                ifm_src = 1'b1; ifm_base = IFM_PING;
                wgt_base = WGT_AW'(23472);   ofm_base = OFM_PONG;
            end
            4'd5: begin
                ifm_size = 9'd19;  ifm_ch = 11'd128;  num_filter = 11'd256;
                kernel_size = 2'd3; pool_en = 1'b1; relu_en = 1'b1;
                ifm_src = 1'b1; ifm_base = IFM_PONG;
                wgt_base = WGT_AW'(97200);   ofm_base = OFM_PING;
            end
            4'd6: begin
                ifm_size = 9'd9;   ifm_ch = 11'd256;  num_filter = 11'd512;
                kernel_size = 2'd3; pool_en = 1'b1; relu_en = 1'b1;
                ifm_src = 1'b1; ifm_base = IFM_PING;
                wgt_base = WGT_AW'(392112);  ofm_base = OFM_PONG;
            end
            4'd7: begin
                ifm_size = 9'd4;   ifm_ch = 11'd512;  num_filter = 11'd1024;
                kernel_size = 2'd3; pool_en = 1'b0; relu_en = 1'b1;
                ifm_src = 1'b1; ifm_base = IFM_PONG;
                wgt_base = WGT_AW'(1571760); ofm_base = OFM_PING;
            end
            4'd8: begin
                ifm_size = 9'd4;   ifm_ch = 11'd1024; num_filter = 11'd16;
                kernel_size = 2'd1; pool_en = 1'b0; relu_en = 1'b0;
                ifm_src = 1'b1; ifm_base = IFM_PING;
                wgt_base = WGT_AW'(6290352); ofm_base = OFM_PONG;
            end
            default: begin
                ifm_size = 9'd0;
            end
        endcase
    end

endmodule

// File: tb/tb_yolov3_tiny_seq.sv
// tb_yolov3_tiny_seq: self-checking bench for the yolov3_tiny_seq layer sequencer.
// dut0 runs the full 8-layer network. dut1 is built with NUM_LAYER=1.
// Set PERF_CNT_EN to include the cycle_cnt checks.
module tb_yolov3_tiny_seq;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic start0, ldone0, start1, ldone1;

    logic        done0, lstart0, done1, lstart1;
    logic [3:0]  cnt0, cnt1;
    logic [8:0]  ifm_size0, ifm_size1;
    logic [10:0] ifm_ch0, ifm_ch1, num_filter0, num_filter1;
    logic [1:0]  ksize0, ksize1;
    logic        pool0, pool1, relu0, relu1, src0, src1;
    logic [63:0] act0, act1;
    logic [21:0] ifm_base0, ifm_base1, ofm_base0, ofm_base1;
    logic [23:0] wgt_base0, wgt_base1;
`ifdef PERF_CNT_EN
    logic [31:0] cycle_cnt0, cycle_cnt1;
`endif

    yolov3_tiny_seq dut0 (
        .clk(clk), .rst_n(rst), .start_CNN(start0), .done_CNN(done0),
        .layer_start(lstart0), .layer_done(ldone0), .count_layer(cnt0),
        .ifm_size(ifm_size0), .ifm_ch(ifm_ch0), .num_filter(num_filter0),
        .kernel_size(ksize0), .pool_en(pool0), .relu_en(relu0), .act_param(act0),
        .ifm_src(src0), .ifm_base(ifm_base0), .wgt_base(wgt_base0), .ofm_base(ofm_base0)
`ifdef PERF_CNT_EN
        , .cycle_cnt(cycle_cnt0)
`endif
    );

    yolov3_tiny_seq #(.NUM_LAYER(1)) dut1 (
        .clk(clk), .rst_n(rst), .start_CNN(start1), .done_CNN(done1),
        .layer_start(lstart1), .layer_done(ldone1), .count_layer(cnt1),
        .ifm_size(ifm_size1), .ifm_ch(ifm_ch1), .num_filter(num_filter1),
        .kernel_size(ksize1), .pool_en(pool1), .relu_en(relu1), .act_param(act1),
        .ifm_src(src1), .ifm_base(ifm_base1), .wgt_base(wgt_base1), .ofm_base(ofm_base1)
`ifdef PERF_CNT_EN
        , .cycle_cnt(cycle_cnt1)
`endif
    );

    int total = 0;
    int bad = 0;

    // The layer_start pulses seen by each DUT, counted on the rising edge.
    int pulses0 = 0;
    int pulses1 = 0;
    always @(posedge clk) begin
        if (lstart0 === 1'b1) pulses0 <= pulses0 + 1;
        if (lstart1 === 1'b1) pulses1 <= pulses1 + 1;
    end

    // ---------------- reference model ----------------
    // This model derives each layer's configuration from the network shape.
    int m_filt[1:8] = '{16, 32, 64, 128, 256, 512, 1024, 16};
    int m_k[1:8]    = '{3, 3, 3, 3, 3, 3, 3, 1};
    int m_pool[1:8] = '{1, 1, 1, 1, 1, 1, 0, 0};
    int m_size[1:8], m_ch[1:8], m_wgt[1:8], m_ofm[1:8], m_ifm[1:8], m_src[1:8], m_relu[1:8];

    task automatic build_model;
        m_size[1] = 318;
        m_ch[1]   = 3;
        m_wgt[1]  = 0;
        for (int n = 1; n <= 8; n++) begin
            if (n < 8) begin
                m_size[n+1] = (m_pool[n] != 0) ? m_size[n] / 2 : m_size[n];
                m_ch[n+1]   = m_filt[n];
                m_wgt[n+1]  = m_wgt[n] + m_ch[n] * m_k[n] * m_k[n] * m_filt[n];
            end
            m_ofm[n]  = (n % 2 == 0) ? 526912 : 0;
            m_src[n]  = (n == 1) ? 0 : 1;
            m_ifm[n]  = (n == 1) ? 0 : m_ofm[n-1];
            m_relu[n] = (n == 8) ? 0 : 1;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // This task waits a bounded number of cycles for a dut0 layer_start. A timeout counts as a failure.
    task automatic wait_launch0(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (lstart0 === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL launch_timeout: got no layer_start, expected one within 20 cycles (count_layer=%0d)", cnt0);
        end
    endtask

    // The engine finishes after lat cycles and pulses layer_done for one cycle.
    task automatic engine_done0(input int lat);
        repeat (lat) tick();
        ldone0 = 1'b1;
        tick();
        ldone0 = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        rst = 1'b1; start0 = 1'b0; ldone0 = 1'b0; start1 = 1'b0; ldone1 = 1'b0;
        tick(); tick();
        rst = 1'b0;
        total++; if (cnt0 !== 4'd0)  begin bad++; $display("FAIL reset_count: got %0d expected 0", cnt0); end
        total++; if (done0 !== 1'b0) begin bad++; $display("FAIL reset_done: got %0b expected 0", done0); end
        total++; if (ifm_size0 !== 9'd0 || wgt_base0 !== 24'd0 || ksize0 !== 2'd0)
                 begin bad++; $display("FAIL reset_cfg: got size=%0d wgt=%0d k=%0d expected all 0", ifm_size0, wgt_base0, ksize0); end
        total++; if (act0 !== 64'd0) begin bad++; $display("FAIL act_param: got %0d expected 0", act0); end
        repeat (3) tick();
        total++; if (pulses0 !== 0 || lstart0 !== 1'b0)
                 begin bad++; $display("FAIL reset_no_start: got %0d pulses expected 0", pulses0); end
    endtask

    task automatic test_full_run;
        bit ok;
        int p0;
        p0 = pulses0;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        total++; if (cnt0 !== 4'd1 || lstart0 !== 1'b0)
                 begin bad++; $display("FAIL start_accept: got count=%0d start=%0b expected 1/0", cnt0, lstart0); end
        for (int n = 1; n <= 8; n++) begin
            wait_launch0(ok);
            if (!ok) return;
            total++; if (int'(cnt0) !== n) begin bad++; $display("FAIL layer_index: got %0d expected %0d", cnt0, n); end
            total++;
            if (int'(ifm_size0) !== m_size[n] || int'(ifm_ch0) !== m_ch[n] ||
                int'(num_filter0) !== m_filt[n] || int'(ksize0) !== m_k[n] ||
                int'(pool0) !== m_pool[n] || int'(relu0) !== m_relu[n]) begin
                bad++;
                $display("FAIL shape_L%0d: got %0d/%0d/%0d/%0d/%0d/%0d expected %0d/%0d/%0d/%0d/%0d/%0d", n,
                         ifm_size0, ifm_ch0, num_filter0, ksize0, pool0, relu0,
                         m_size[n], m_ch[n], m_filt[n], m_k[n], m_pool[n], m_relu[n]);
            end
            total++;
            if (int'(wgt_base0) !== m_wgt[n] || int'(ofm_base0) !== m_ofm[n] ||
                int'(ifm_base0) !== m_ifm[n] || int'(src0) !== m_src[n]) begin
                bad++;
                $display("FAIL addr_L%0d: got wgt=%0d ofm=%0d ifm=%0d src=%0d expected %0d/%0d/%0d/%0d", n,
                         wgt_base0, ofm_base0, ifm_base0, src0, m_wgt[n], m_ofm[n], m_ifm[n], m_src[n]);
            end
            tick();
            total++; if (lstart0 !== 1'b0) begin bad++; $display("FAIL pulse_width_L%0d: got 1 expected 0", n); end
            engine_done0($urandom_range(0, 10));
            if (n < 8) begin
                total++; if (done0 !== 1'b0) begin bad++; $display("FAIL early_done_L%0d: got 1 expected 0", n); end
            end
        end
        total++; if (done0 !== 1'b1) begin bad++; $display("FAIL done_after_last: got %0b expected 1", done0); end
        repeat (4) tick();
        total++; if (pulses0 - p0 !== 8) begin bad++; $display("FAIL launch_total: got %0d expected 8", pulses0 - p0); end
        total++; if (done0 !== 1'b1) begin bad++; $display("FAIL done_level: got %0b expected 1", done0); end
    endtask

    task automatic test_restart_abort;
        bit ok;
        int p0;
        // A layer_done pulse in DONE is ignored.
        ldone0 = 1'b1; tick(); ldone0 = 1'b0; tick();
        total++; if (done0 !== 1'b1) begin bad++; $display("FAIL done_ignores_ldone: got %0b expected 1", done0); end
        // A start in DONE restarts the network at layer 1.
        start0 = 1'b1; tick(); start0 = 1'b0;
        total++; if (done0 !== 1'b0 || cnt0 !== 4'd1)
                 begin bad++; $display("FAIL restart: got done=%0b count=%0d expected 0/1", done0, cnt0); end
        // A layer_done that coincides with layer_start is dropped.
        wait_launch0(ok);
        if (!ok) return;
        p0 = pulses0;
        ldone0 = 1'b1; tick(); ldone0 = 1'b0;
        repeat (4) tick();
        total++; if (cnt0 !== 4'd1 || pulses0 - p0 !== 1)
                 begin bad++; $display("FAIL coincident_done: got count=%0d pulses=%0d expected 1/1", cnt0, pulses0 - p0); end
        engine_done0(0);
        wait_launch0(ok);
        if (!ok) return;
        engine_done0($urandom_range(1, 6));
        // A start during RUN of layer 3 is ignored.
        wait_launch0(ok);
        if (!ok) return;
        tick(); tick();
        p0 = pulses0;
        start0 = 1'b1; tick(); start0 = 1'b0;
        repeat (4) tick();
        total++; if (cnt0 !== 4'd3 || pulses0 !== p0)
                 begin bad++; $display("FAIL start_in_run: got count=%0d new_pulses=%0d expected 3/0", cnt0, pulses0 - p0); end
        engine_done0(0);
        wait_launch0(ok);
        if (!ok) return;
        engine_done0($urandom_range(1, 6));
        // A reset at layer 5 aborts the run to IDLE.
        wait_launch0(ok);
        if (!ok) return;
        total++; if (cnt0 !== 4'd5) begin bad++; $display("FAIL reach_L5: got %0d expected 5", cnt0); end
        tick();
        rst = 1'b1; tick(); rst = 1'b0;
        total++; if (cnt0 !== 4'd0 || done0 !== 1'b0 || lstart0 !== 1'b0)
                 begin bad++; $display("FAIL abort: got count=%0d done=%0b start=%0b expected 0/0/0", cnt0, done0, lstart0); end
        p0 = pulses0;
        repeat (5) tick();
        total++; if (pulses0 !== p0 || cnt0 !== 4'd0)
                 begin bad++; $display("FAIL abort_idle: got pulses=%0d count=%0d expected 0/0", pulses0 - p0, cnt0); end
    endtask

    task automatic test_single_layer;
        bit ok;
        int p1;
        p1 = pulses1;
        start1 = 1'b1; tick(); start1 = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (lstart1 === 1'b1) begin ok = 1'b1; break; end
            tick();
        end
        total++; if (!ok) begin bad++; $display("FAIL single_launch: got no layer_start expected one"); end
        if (!ok) return;
        repeat (10) tick();
        ldone1 = 1'b1; tick(); ldone1 = 1'b0;
        total++; if (done1 !== 1'b1) begin bad++; $display("FAIL single_done: got %0b expected 1", done1); end
`ifdef PERF_CNT_EN
        total++; if (cycle_cnt1 !== 32'd12) begin bad++; $display("FAIL cycle_cnt: got %0d expected 12", cycle_cnt1); end
`endif
        repeat (4) tick();
        total++; if (pulses1 - p1 !== 1 || done1 !== 1'b1)
                 begin bad++; $display("FAIL single_total: got pulses=%0d done=%0b expected 1/1", pulses1 - p1, done1); end
`ifdef PERF_CNT_EN
        total++; if (cycle_cnt1 !== 32'd12) begin bad++; $display("FAIL cycle_cnt_frozen: got %0d expected 12", cycle_cnt1); end
`endif
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        build_model();
        test_reset();
        test_full_run();
        test_restart_abort();
        test_single_layer();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
